// File: rtl/i2c_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_init_sequencer
// Summary  : Walks a ROM register-init table and issues one 3-byte write per
//            entry to an i2c_master; supports delay entries and an end marker.
// Revision : 1.0
// ============================================================================
module i2c_init_sequencer #(
    parameter int          NUM_CMDS       = 16,
    parameter logic [7:0]  DEV_ID         = 8'h50,
    parameter int          DELAY_UNIT     = 1000,
    parameter int          GAP_CYCLES     = 4,
    parameter int          ACCEPT_TIMEOUT = 8,
    localparam int         AW             = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    output logic [AW-1:0] cmd_addr,
    input  logic [15:0]   cmd_word,
    input  logic          m_ready,
    output logic          m_start,
    output logic [7:0]    m_dev_id,
    output logic [7:0]    m_reg_id,
    output logic [7:0]    m_data,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] cmd_index
);

    localparam int c_unit_w   = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT + 1) : 1;
    localparam int c_wait_max = (ACCEPT_TIMEOUT > GAP_CYCLES) ? ACCEPT_TIMEOUT : GAP_CYCLES;
    localparam int c_cnt_w    = (c_wait_max > 1) ? $clog2(c_wait_max + 1) : 1;

    localparam logic [AW-1:0]       c_idx_last    = AW'(NUM_CMDS - 1);
    localparam logic [AW-1:0]       c_idx_one     = AW'(1);
    localparam logic [c_unit_w-1:0] c_unit_reload = c_unit_w'(DELAY_UNIT - 1);
    localparam logic [c_unit_w-1:0] c_unit_one    = c_unit_w'(1);
    localparam logic [c_cnt_w-1:0]  c_accept_last = c_cnt_w'(ACCEPT_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0]  c_gap_last    = c_cnt_w'(GAP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one     = c_cnt_w'(1);
    localparam logic [7:0]          c_reg_end     = 8'hFE;
    localparam logic [7:0]          c_reg_delay   = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_FETCH       = 4'd1,
        S_DECODE      = 4'd2,
        S_ISSUE       = 4'd3,
        S_WAIT_ACCEPT = 4'd4,
        S_WAIT_DONE   = 4'd5,
        S_GAP         = 4'd6,
        S_DELAY       = 4'd7,
        S_DONE        = 4'd8,
        S_ERROR       = 4'd9
    } state_t;

    state_t              r_state,  w_state_n;
    logic [AW-1:0]       r_index,  w_index_n;
    logic [c_cnt_w-1:0]  r_cnt,    w_cnt_n;
    logic [7:0]          r_ticks,  w_ticks_n;
    logic [c_unit_w-1:0] r_unit,   w_unit_n;
    logic [7:0]          r_reg_id, w_reg_id_n;
    logic [7:0]          r_data,   w_data_n;
    logic                w_start;
    logic                w_advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_index  <= '0;
            r_cnt    <= '0;
            r_ticks  <= '0;
            r_unit   <= '0;
            r_reg_id <= '0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state_n;
            r_index  <= w_index_n;
            r_cnt    <= w_cnt_n;
            r_ticks  <= w_ticks_n;
            r_unit   <= w_unit_n;
            r_reg_id <= w_reg_id_n;
            r_data   <= w_data_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_index_n  = r_index;
        w_cnt_n    = r_cnt;
        w_ticks_n  = r_ticks;
        w_unit_n   = r_unit;
        w_reg_id_n = r_reg_id;
        w_data_n   = r_data;
        w_start    = 1'b0;
        w_advance  = 1'b0;

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (go) begin
                    w_index_n = '0;
                    w_state_n = S_FETCH;
                end
            end
            S_FETCH: w_state_n = S_DECODE;
            S_DECODE: begin
                if (cmd_word[15:8] == c_reg_end) begin
                    w_state_n = S_DONE;
                end else if (cmd_word[15:8] == c_reg_delay) begin
                    if (cmd_word[7:0] == 8'd0) begin
                        w_cnt_n   = '0;
                        w_state_n = S_GAP;
                    end else begin
                        w_ticks_n = cmd_word[7:0];
                        w_unit_n  = c_unit_reload;
                        w_state_n = S_DELAY;
                    end
                end else begin
                    w_reg_id_n = cmd_word[15:8];
                    w_data_n   = cmd_word[7:0];
                    w_state_n  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (m_ready) begin
                    w_start   = 1'b1;
                    w_cnt_n   = '0;
                    w_state_n = S_WAIT_ACCEPT;
                end
            end
            S_WAIT_ACCEPT: begin
                // Master acknowledges a start by dropping ready.
                if (!m_ready) begin
                    w_state_n = S_WAIT_DONE;
                end else if (r_cnt == c_accept_last) begin
                    w_state_n = S_ERROR;
                end else begin
                    w_cnt_n = r_cnt + c_cnt_one;
                end
            end
            S_WAIT_DONE: begin
                if (m_ready) begin
                    w_cnt_n   = '0;
                    w_state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == c_gap_last) begin
                    w_advance = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + c_cnt_one;
                end
            end
            S_DELAY: begin
                // Ticks are consumed on unit wrap, so the last wrap ends the delay.
                if (r_unit == '0) begin
                    w_unit_n  = c_unit_reload;
                    w_ticks_n = r_ticks - 8'd1;
                    if (r_ticks <= 8'd1) begin
                        w_advance = 1'b1;
                    end
                end else begin
                    w_unit_n = r_unit - c_unit_one;
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        if (w_advance) begin
            if (r_index == c_idx_last) begin
                w_state_n = S_DONE;
            end else begin
                w_index_n = r_index + c_idx_one;
                w_state_n = S_FETCH;
            end
        end
    end

    assign m_start   = w_start & ~reset;
    assign m_dev_id  = DEV_ID;
    assign m_reg_id  = r_reg_id;
    assign m_data    = r_data;
    assign cmd_addr  = r_index;
    assign cmd_index = r_index;
    assign done      = (r_state == S_DONE);
    assign error     = (r_state == S_ERROR);
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_init_sequencer
// Summary  : Scoreboard bench: ROM + i2c_master model, directed table runs.
// Revision : 1.0
// ============================================================================
module tb_i2c_init_sequencer;

    localparam int NUM_CMDS   = 4;
    localparam int DELAY_UNIT = 10;
    localparam int AW         = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   cmd_word = 16'hFE00;
    logic          m_ready;
    logic          m_start;
    logic [7:0]    m_dev_id, m_reg_id, m_data;
    logic          busy, done, error;
    logic [AW-1:0] cmd_index;

    always #5 clk = ~clk;

    i2c_init_sequencer #(
        .NUM_CMDS       (NUM_CMDS),
        .DEV_ID         (8'h50),
        .DELAY_UNIT     (DELAY_UNIT),
        .GAP_CYCLES     (4),
        .ACCEPT_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .cmd_addr  (cmd_addr),
        .cmd_word  (cmd_word),
        .m_ready   (m_ready),
        .m_start   (m_start),
        .m_dev_id  (m_dev_id),
        .m_reg_id  (m_reg_id),
        .m_data    (m_data),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cmd_index (cmd_index)
    );

    // Synchronous ROM, one cycle read latency
    logic [15:0] rom [NUM_CMDS];
    always @(posedge clk) cmd_word <= rom[cmd_addr];

    // i2c_master model: ready drops the cycle after a start, rises busy_len+1 cycles later
    logic mrdy = 1'b1;
    int   mcnt = 0;
    int   busy_len = 6;
    logic master_en = 1'b1;
    logic stall = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            mrdy <= 1'b1;
            mcnt <= 0;
        end else if (mrdy && m_start) begin
            mrdy <= 1'b0;
            mcnt <= busy_len;
        end else if (!mrdy) begin
            if (mcnt == 0) mrdy <= 1'b1;
            else           mcnt <= mcnt - 1;
        end
    end
    assign m_ready = master_en ? (mrdy && !stall) : 1'b1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    int          start_cnt = 0;
    int          start_cyc = 0;
    logic        prev_start = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: every start pulse is matched against the scoreboard queue
    always @(negedge clk) begin
        if (m_start === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
            check("start_single_cycle", 32'(prev_start), 32'd0);
            check("dev_id", 32'(m_dev_id), 32'h50);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_start: got reg/data %h, expected no write", {m_reg_id, m_data});
            end else begin
                check("write_reg_data", 32'({m_reg_id, m_data}), 32'(exp_q.pop_front()));
            end
        end
        prev_start = m_start;
    end

    task automatic load_rom(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_end(input string name, input int max);
        int k = 0;
        while (!(done || error) && k < max) begin
            @(negedge clk);
            k++;
        end
        if (!(done || error)) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no done/error, expected one within %0d cycles", name, max);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_m_start"},   32'(m_start),   32'd0);
        check({tag, "_m_reg_id"},  32'(m_reg_id),  32'd0);
        check({tag, "_m_data"},    32'(m_data),    32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_error"},     32'(error),     32'd0);
        check({tag, "_cmd_addr"},  32'(cmd_addr),  32'd0);
        check({tag, "_cmd_index"}, 32'(cmd_index), 32'd0);
        check({tag, "_m_dev_id"},  32'(m_dev_id),  32'h50);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int dec_cyc;
        int k;
        load_rom(16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: two writes then end marker
        load_rom(16'h12AA, 16'h3455, 16'hFE00, 16'hFE00);
        base = start_cnt;
        exp_q.push_back(16'h12AA);
        exp_q.push_back(16'h3455);
        pulse_go();
        wait_end("t1_end", 2000);
        check("t1_done",   32'(done),      32'd1);
        check("t1_busy",   32'(busy),      32'd0);
        check("t1_error",  32'(error),     32'd0);
        check("t1_index",  32'(cmd_index), 32'd2);
        check("t1_writes", 32'(start_cnt - base), 32'd2);
        check("t1_queue",  32'(exp_q.size()), 32'd0);

        // 2: delay entry of 3 ticks x 10 cycles before the first write
        load_rom(16'hFF03, 16'h0101, 16'hFE00, 16'hFE00);
        base = start_cnt;
        exp_q.push_back(16'h0101);
        pulse_go();
        dec_cyc = cyc + 1;
        wait_end("t2_end", 2000);
        check("t2_writes", 32'(start_cnt - base), 32'd1);
        check_range("t2_delay_latency", start_cyc - dec_cyc, 30, 35);
        check("t2_done",   32'(done),      32'd1);
        check("t2_index",  32'(cmd_index), 32'd2);

        // 3: full table without end marker
        load_rom(16'h0111, 16'h0222, 16'h0333, 16'h0444);
        base = start_cnt;
        exp_q.push_back(16'h0111);
        exp_q.push_back(16'h0222);
        exp_q.push_back(16'h0333);
        exp_q.push_back(16'h0444);
        pulse_go();
        wait_end("t3_end", 4000);
        check("t3_writes",   32'(start_cnt - base), 32'd4);
        check("t3_done",     32'(done),      32'd1);
        check("t3_index",    32'(cmd_index), 32'd3);
        check("t3_cmd_addr", 32'(cmd_addr),  32'd3);
        check("t3_queue",    32'(exp_q.size()), 32'd0);

        // 4: no master, ready stuck high -> accept timeout
        master_en = 1'b0;
        load_rom(16'h1234, 16'hFE00, 16'hFE00, 16'hFE00);
        base = start_cnt;
        exp_q.push_back(16'h1234);
        pulse_go();
        wait_end("t4_end", 500);
        check("t4_error",  32'(error),     32'd1);
        check("t4_done",   32'(done),      32'd0);
        check("t4_busy",   32'(busy),      32'd0);
        check("t4_index",  32'(cmd_index), 32'd0);
        check("t4_writes", 32'(start_cnt - base), 32'd1);
        check_range("t4_timeout_latency", cyc - start_cyc, 8, 9);
        master_en = 1'b1;
        repeat (12) @(negedge clk);
        base = start_cnt;
        exp_q.push_back(16'h1234);
        pulse_go();
        check("t4_restart_error", 32'(error),     32'd0);
        check("t4_restart_busy",  32'(busy),      32'd1);
        check("t4_restart_index", 32'(cmd_index), 32'd0);
        wait_end("t4_restart_end", 2000);
        check("t4_restart_done",   32'(done),  32'd1);
        check("t4_restart_err2",   32'(error), 32'd0);
        check("t4_restart_writes", 32'(start_cnt - base), 32'd1);

        // 5: ready low when ISSUE is entered
        load_rom(16'h5A5A, 16'hFE00, 16'hFE00, 16'hFE00);
        stall = 1'b1;
        base = start_cnt;
        exp_q.push_back(16'h5A5A);
        pulse_go();
        repeat (10) @(negedge clk);
        check("t5_no_start", 32'(start_cnt - base), 32'd0);
        check("t5_busy",     32'(busy), 32'd1);
        stall = 1'b0;
        wait_end("t5_end", 2000);
        check("t5_writes", 32'(start_cnt - base), 32'd1);
        check("t5_done",   32'(done), 32'd1);

        // 6a: reset during WAIT_DONE of entry 1
        load_rom(16'h1111, 16'h2222, 16'h3333, 16'hFE00);
        busy_len = 30;
        base = start_cnt;
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        pulse_go();
        k = 0;
        while (start_cnt - base < 2 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t6_second_start", 32'(start_cnt - base), 32'd2);
        repeat (3) @(negedge clk);
        check("t6_busy_pre",  32'(busy),      32'd1);
        check("t6_index_pre", 32'(cmd_index), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("t6_rst");
        reset = 1'b0;
        busy_len = 6;
        repeat (5) @(negedge clk);
        check("t6_no_more_starts", 32'(start_cnt - base), 32'd2);
        check("t6_idle_busy",      32'(busy), 32'd0);
        check("t6_queue",          32'(exp_q.size()), 32'd0);

        // 6b: go while busy is ignored
        load_rom(16'h7777, 16'hFE00, 16'hFE00, 16'hFE00);
        base = start_cnt;
        exp_q.push_back(16'h7777);
        pulse_go();
        repeat (12) begin
            go = 1'b1;
            @(negedge clk);
        end
        go = 1'b0;
        check("t6b_busy", 32'(busy), 32'd1);
        wait_end("t6b_end", 2000);
        check("t6b_writes", 32'(start_cnt - base), 32'd1);
        check("t6b_done",   32'(done),      32'd1);
        check("t6b_index",  32'(cmd_index), 32'd1);
        check("t6b_queue",  32'(exp_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
Upstream command source for the i2c_master write engine. On a go pulse it walks a register-init table (external synchronous ROM) and issues one 3-byte I2C write (dev_id, reg_id, data) per entry through the master's start/ready handshake. It supports inline delay entries and an end-of-table marker, and it reports busy, done and error status to the top level for camera or codec bring-up.

Parameters:
NUM_CMDS, 16, maximum table entries; cmd_addr width = $clog2(NUM_CMDS), minimum 1
DEV_ID, 8'h50, device address placed on dev_id; the master transmits bits [6:0]
DELAY_UNIT, 1000, clk cycles per delay tick for delay entries
GAP_CYCLES, 4, idle cycles between a completed write and the next fetch; must be >= 1
ACCEPT_TIMEOUT, 8, cycles allowed for master ready to fall after start

Ports:
clk  in  1  system clock; same clock as i2c_master
reset  in  1  reset, synchronous, active-high
go  in  1  start a table run; sampled only in IDLE, DONE, ERROR
cmd_addr  out  AW  ROM read address
cmd_word  in  16  ROM data {reg[15:8], data[7:0]}, valid 1 cycle after cmd_addr
m_ready  in  1  i2c_master ready
m_start  out  1  i2c_master start, one-cycle pulse
m_dev_id  out  8  to master dev_id, constant DEV_ID
m_reg_id  out  8  to master reg_id
m_data  out  8  to master data
busy  out  1  high in every state except IDLE, DONE, ERROR
done  out  1  table completed; held until the next go or reset
error  out  1  master failed to accept a command; held until the next go or reset
cmd_index  out  AW  index of the current or last entry

Behaviour:
- Reset values: state IDLE; m_start, m_reg_id, m_data, busy, done, error, cmd_addr, cmd_index all 0; m_dev_id = DEV_ID at all times.
- Reset is honoured in any state, including mid-write. A pending start pulse is dropped. The master resets on the same signal.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_ACCEPT, WAIT_DONE, GAP, DELAY, DONE, ERROR.
- IDLE / DONE / ERROR:
  - go=1: clear done and error, set index=0, drive cmd_addr=0, go to FETCH.
  - go while busy is ignored.
- FETCH: one cycle for ROM latency, then DECODE.
- DECODE (cmd_word valid), evaluated in this order:
  - reg==8'hFE: end marker, go to DONE.
  - reg==8'hFF: delay entry. Load tick counter = data and unit counter = DELAY_UNIT-1, go to DELAY. If data==0, go straight to GAP.
  - otherwise: register m_reg_id/m_data from cmd_word, go to ISSUE.
- ISSUE: if m_ready=1, drive m_start=1 for exactly this cycle and go to WAIT_ACCEPT. Otherwise hold in ISSUE with m_start=0.
- m_reg_id and m_data stay stable from ISSUE until the next DECODE.
- WAIT_ACCEPT: wait for m_ready=0, then go to WAIT_DONE. If m_ready does not fall within ACCEPT_TIMEOUT cycles, go to ERROR; cmd_index keeps the failing entry.
- WAIT_DONE: wait for m_ready=1. No timeout, since the master has none of its own. Then go to GAP.
- GAP: count GAP_CYCLES cycles, then advance.
- DELAY: decrement the unit counter each cycle. On wrap, decrement ticks; at ticks==0, advance. Total delay = data*DELAY_UNIT cycles, ±2.
- Advance: if index==NUM_CMDS-1, go to DONE. Otherwise index+1, cmd_addr=index+1, go to FETCH. The index never wraps.
- DONE: done=1, busy=0. ERROR: error=1, busy=0. done and error are never high together.
- Write-command throughput: DECODE to m_start takes 1 cycle when m_ready is high.
- Counter widths: tick counter 8 bits; unit counter $clog2(DELAY_UNIT+1).

Test Plan:
1. ROM {0x12AA, 0x3455, 0xFE00}, master model present, go pulse:
   - exactly 2 m_start pulses, with reg/data 0x12/0xAA then 0x34/0x55
   - m_dev_id = 0x50 throughout
   - done=1, busy=0, cmd_index=2 at the end
2. ROM {0xFF03, 0x0101, 0xFE00}, DELAY_UNIT=10:
   - first m_start occurs ≥30 cycles after the delay entry's DECODE
   - no m_start is issued for the delay entry itself
3. Full table, NUM_CMDS=4, no end marker:
   - exactly 4 writes
   - done after index 3, cmd_addr never exceeds 3
4. m_ready held high permanently (no master):
   - one m_start, then error=1 after 8 cycles
   - cmd_index=0, busy=0
   - a following go clears error and restarts from entry 0
5. m_ready low when ISSUE is entered: m_start stays 0 until m_ready rises, then pulses for exactly 1 cycle.
6. Robustness:
   - reset asserted during WAIT_DONE of entry 1: all outputs return to reset values next cycle
   - go while busy: no restart and no extra m_start
